// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_t;

  // Byte enables for an access of size funct3 starting at byte lane addr_lo.
  function automatic logic [3:0] be_of(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr_lo;
      F3_H, F3_HU: be = 4'b0011 << addr_lo;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication, byte enables, load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  be_c,
  output logic [31:0] st_lane_c,
  output logic [31:0] ld_data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be_c      = be_of(funct3_i, addr_lo_i);
    st_lane_c = st_data_i;
    ld_data_c = ld_word_i;
    byte_v    = ld_word_i[{addr_lo_i, 3'b000} +: 8];
    half_v    = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (funct3_i)
      F3_B: begin
        st_lane_c = {4{st_data_i[7:0]}};
        ld_data_c = {{24{byte_v[7]}}, byte_v};
      end
      F3_BU: ld_data_c = {24'd0, byte_v};
      F3_H: begin
        st_lane_c = {2{st_data_i[15:0]}};
        ld_data_c = {{16{half_v[15]}}, half_v};
      end
      F3_HU: ld_data_c = {16'd0, half_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: request checks, memory issue, read-latency wait, held response.
module rv32i_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDWIDTH = 12,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [4:0]          req_rd,
  output logic [ADDWIDTH-1:0] mem_addr,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  output logic                mem_re,
  input  logic [31:0]         mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_data,
  output logic [4:0]          resp_rd,
  output logic                resp_err
);

  localparam int unsigned CNT_W = 2;

  lsu_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                store_q, store_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          lo_q, lo_d;
  logic                req_ready_q, req_ready_d;
  logic [ADDWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic [4:0]          resp_rd_q, resp_rd_d;
  logic                resp_err_q, resp_err_d;

  logic [2:0]  al_f3_c;
  logic [1:0]  al_lo_c;
  logic [3:0]  be_c;
  logic [31:0] st_lane_c, ld_data_c;
  logic        misal_c, oor_c, ill_c, req_err_c;

  // Steering uses the live request while idle, the latched one afterwards.
  assign al_f3_c = (state_q == IDLE) ? req_funct3 : f3_q;
  assign al_lo_c = (state_q == IDLE) ? req_addr[1:0] : lo_q;

  lsu_align u_align (
    .funct3_i  (al_f3_c),
    .addr_lo_i (al_lo_c),
    .st_data_i (req_wdata),
    .ld_word_i (mem_rdata),
    .be_c      (be_c),
    .st_lane_c (st_lane_c),
    .ld_data_c (ld_data_c)
  );

  assign misal_c   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                   || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign oor_c     = (req_addr >> (ADDWIDTH + 2)) != 32'd0;
  assign ill_c     = req_store ? (req_funct3 > F3_W)
                               : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
  assign req_err_c = misal_c || oor_c || ill_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    resp_data_d = resp_data_q;
    resp_rd_d   = resp_rd_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          store_d     = req_store;
          f3_d        = req_funct3;
          lo_d        = req_addr[1:0];
          resp_rd_d   = req_rd;
          resp_data_d = 32'd0;
          resp_err_d  = req_err_c;
          if (req_err_c) begin
            state_d = RESP;
          end else begin
            state_d    = ISSUE;
            mem_addr_d = req_addr[ADDWIDTH+1:2];
            if (req_store) begin
              mem_we_d    = 1'b1;
              mem_be_d    = be_c;
              mem_wdata_d = st_lane_c;
            end else begin
              mem_re_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (store_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          resp_data_d = ld_data_c;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      f3_q         <= '0;
      lo_q         <= '0;
      req_ready_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      f3_q         <= f3_d;
      lo_q         <= lo_d;
      req_ready_q  <= req_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: vector table with response scoreboard, plus reset-in-ISSUE sequence.
module tb_rv32i_lsu;

  localparam int unsigned ADDWIDTH = 12;
  localparam int unsigned RD_LAT   = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid, req_ready, req_store;
  logic [2:0]          req_funct3;
  logic [31:0]         req_addr, req_wdata;
  logic [4:0]          req_rd;
  logic [ADDWIDTH-1:0] mem_addr;
  logic                mem_we, mem_re;
  logic [3:0]          mem_be;
  logic [31:0]         mem_wdata, mem_rdata;
  logic                resp_valid, resp_ready;
  logic [31:0]         resp_data;
  logic [4:0]          resp_rd;
  logic                resp_err;

  rv32i_lsu #(.ADDWIDTH(ADDWIDTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Data memory with per-byte writes and an RD_LAT-deep read pipe.
  logic [31:0] mem  [0:(1<<ADDWIDTH)-1];
  logic [31:0] pipe [0:RD_LAT-1];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << ADDWIDTH); i++) mem[i] <= 32'd0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pipe[0] <= mem_re ? mem[mem_addr] : 32'hDEADBEEF;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          stall;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] xd,
                     input logic xe, input logic [3:0] xbe, input logic [31:0] xwd, input int stall);
    vec_t v;
    v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rd = rd;
    v.exp_data = xd; v.exp_err = xe; v.exp_be = xbe; v.exp_wd = xwd; v.stall = stall;
    vecs.push_back(v);
  endtask

  task automatic junk();
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
  endtask

  task automatic do_req(input vec_t v);
    exp_t        e;
    int          cyc, we_n, re_n, lat;
    logic [31:0] a;
    a   = v.addr;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    e.data = v.exp_data; e.rd = v.rd; e.err = v.exp_err;
    sb_q.push_back(e);
    lat = v.exp_err ? 1 : (v.store ? 2 : 2 + int'(RD_LAT));
    @(posedge clk); #1;
    cyc = 1; we_n = 0; re_n = 0;
    // Keep req_valid high with garbage: it must be ignored outside IDLE.
    while (!resp_valid && cyc < 20) begin
      junk();
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (mem_we) begin
        we_n++;
        chk("mem_be", 32'(mem_be), 32'(v.exp_be));
        chk("mem_wdata", mem_wdata, v.exp_wd);
        chk("mem_addr_wr", 32'(mem_addr), 32'(a[ADDWIDTH+1:2]));
      end
      if (mem_re) begin
        re_n++;
        chk("mem_addr_rd", 32'(mem_addr), 32'(a[ADDWIDTH+1:2]));
      end
      @(posedge clk); #1; cyc++;
    end
    req_valid = 1'b0;
    chk("resp_latency", 32'(cyc), 32'(lat));
    chk("mem_we_cycles", 32'(we_n), 32'(v.store && !v.exp_err));
    chk("mem_re_cycles", 32'(re_n), 32'(!v.store && !v.exp_err));
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got response with no expectation");
    end else begin
      e = sb_q.pop_front();
      chk("resp_data", resp_data, e.data);
      chk("resp_rd", 32'(resp_rd), 32'(e.rd));
      chk("resp_err", 32'(resp_err), 32'(e.err));
    end
    if (v.stall > 0) resp_ready = 1'b0;
    for (int k = 0; k < v.stall; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", resp_data, e.data);
      chk("stall_rd", 32'(resp_rd), 32'(e.rd));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // store, f3, addr, wdata, rd, exp_data, exp_err, exp_be, exp_wdata, stall
    add(1, 3'b000, 32'h6,    32'hAABBCCDD, 5'd2,  32'h0,        0, 4'b0100, 32'hDDDDDDDD, 0);
    add(0, 3'b010, 32'h4,    32'h0,        5'd3,  32'h00DD0000, 0, 4'b0000, 32'h0,        0);
    add(1, 3'b010, 32'h4,    32'h80FF7F01, 5'd4,  32'h0,        0, 4'b1111, 32'h80FF7F01, 0);
    add(0, 3'b000, 32'h5,    32'h0,        5'd5,  32'h0000007F, 0, 4'b0000, 32'h0,        0);
    add(0, 3'b000, 32'h6,    32'h0,        5'd6,  32'hFFFFFFFF, 0, 4'b0000, 32'h0,        0);
    add(0, 3'b100, 32'h7,    32'h0,        5'd7,  32'h00000080, 0, 4'b0000, 32'h0,        0);
    add(0, 3'b001, 32'h6,    32'h0,        5'd8,  32'hFFFF80FF, 0, 4'b0000, 32'h0,        0);
    add(0, 3'b101, 32'h6,    32'h0,        5'd9,  32'h000080FF, 0, 4'b0000, 32'h0,        4);
    add(0, 3'b010, 32'h2,    32'h0,        5'd10, 32'h0,        1, 4'b0000, 32'h0,        0);
    add(1, 3'b001, 32'h3,    32'h5555AAAA, 5'd11, 32'h0,        1, 4'b0000, 32'h0,        0);
    add(0, 3'b010, 32'h4000, 32'h0,        5'd12, 32'h0,        1, 4'b0000, 32'h0,        0);
    add(0, 3'b010, 32'h80000000, 32'h0,    5'd13, 32'h0,        1, 4'b0000, 32'h0,        0);
    add(0, 3'b011, 32'h0,    32'h0,        5'd14, 32'h0,        1, 4'b0000, 32'h0,        0);
    add(0, 3'b110, 32'h0,    32'h0,        5'd15, 32'h0,        1, 4'b0000, 32'h0,        0);
    add(1, 3'b100, 32'h0,    32'h11111111, 5'd16, 32'h0,        1, 4'b0000, 32'h0,        0);
    add(1, 3'b001, 32'h2,    32'h1234ABCD, 5'd17, 32'h0,        0, 4'b1100, 32'hABCDABCD, 0);
    add(0, 3'b010, 32'h0,    32'h0,        5'd18, 32'hABCD0000, 0, 4'b0000, 32'h0,        2);
    add(0, 3'b001, 32'h2,    32'h0,        5'd19, 32'hFFFFABCD, 0, 4'b0000, 32'h0,        0);
    add(0, 3'b000, 32'h3,    32'h0,        5'd20, 32'hFFFFFFAB, 0, 4'b0000, 32'h0,        0);
    add(1, 3'b010, 32'h10,   32'h12345678, 5'd21, 32'h0,        0, 4'b1111, 32'h12345678, 0);
    add(0, 3'b010, 32'h10,   32'h0,        5'd22, 32'h12345678, 0, 4'b0000, 32'h0,        0);
    add(0, 3'b010, 32'h8,    32'h0,        5'd23, 32'h0,        0, 4'b0000, 32'h0,        4);
    add(1, 3'b000, 32'h13,   32'h000000EE, 5'd24, 32'h0,        0, 4'b1000, 32'hEEEEEEEE, 0);
    add(0, 3'b010, 32'h10,   32'h0,        5'd25, 32'hEE345678, 0, 4'b0000, 32'h0,        0);

    rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_rd", 32'(resp_rd), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    mem_clr = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) do_req(vecs[i]);

    // Reset pulsed while a SW sits in ISSUE.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'hC; req_wdata = 32'hCAFEF00D; req_rd = 5'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("issue_mem_we", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we", 32'(mem_we), 32'd0);
    chk("rst_async_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("rst_ready_after", 32'(req_ready), 32'd1);
    begin
      vec_t v;
      v.store = 0; v.f3 = 3'b010; v.addr = 32'hC; v.wdata = 0; v.rd = 5'd26;
      v.exp_data = 32'h0; v.exp_err = 0; v.exp_be = 4'b0000; v.exp_wd = 32'h0; v.stall = 0;
      do_req(v);
      v.addr = 32'h10; v.rd = 5'd27; v.exp_data = 32'hEE345678; v.stall = 1;
      do_req(v);
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit between the execute stage and the data memory. Accepts one RV32I load or store per handshake, checks alignment and range, and drives the word-addressed byte-enable memory port. Load data is extracted and sign- or zero-extended, then returned on a held response channel. The memory port is word-wide with per-byte write enables and a fixed read latency.

## Interface

Parameters:
- `ADDWIDTH`, default 12: word-address width of data memory; `2**ADDWIDTH` words.
- `RD_LAT`, default 1: memory read latency in cycles; legal values are 1..3.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept a request. High only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- `req_addr` in 32: byte address (rs1 + imm).
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination; returned unchanged.
- `mem_addr` out ADDWIDTH: word address = `req_addr[ADDWIDTH+1:2]`.
- `mem_we` out 1: write strobe, one cycle.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-aligned store data.
- `mem_re` out 1: read strobe, one cycle.
- `mem_rdata` in 32: read word, valid `RD_LAT` cycles after `mem_re`.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 32: extended load data; 0 for stores and errors.
- `resp_rd` out 5: echoed `req_rd`.
- `resp_err` out 1: misaligned, out of range, or illegal funct3.

## Operation

- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready=1`. On `req_valid`, latch all request fields.
  - Any error goes to RESP with `resp_err=1`; otherwise go to ISSUE.
- Error checks:
  - Misaligned: halfword access with `addr[0]=1`; word access with `addr[1:0]!=0`.
  - Out of range: `addr[31:ADDWIDTH+2]!=0`.
  - Illegal funct3: load funct3 of 011, 110 or 111; store funct3 above 010.
  - An erroring request never asserts `mem_we` or `mem_re`.
- ISSUE is one cycle, with `mem_addr` valid.
  - Store: `mem_we=1`, then go to RESP.
    - SB: `be = 0001 << addr[1:0]`, `wdata = {4{d[7:0]}}`.
    - SH: `be = 0011 << addr[1:0]`, `wdata = {2{d[15:0]}}`.
    - SW: `be = 1111`, `wdata = d`.
  - Load: `mem_re=1`, load the latency counter with `RD_LAT`, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, capture `mem_rdata`, extract, and go to RESP.
- Load extraction:
  - LB/LBU take byte `addr[1:0]`, sign- or zero-extended.
  - LH/LHU take halfword `addr[1]`, sign- or zero-extended.
  - LW takes the whole word.
- RESP:
  - `resp_valid=1`; all resp fields stay stable until `resp_ready`.
  - On `resp_ready`, go to IDLE.
  - No new request is accepted in the same cycle (`req_ready=0` in RESP).

## Timing

- All outputs are registered.
- Reset values: `req_ready=0` while `rst` is high, then 1 on the first cycle after release. All other outputs are 0 and the state is IDLE.
- Store: accept at cycle N, `mem_we` at N+1, `resp_valid` at N+2.
- Load: accept at N, `mem_re` at N+1, data captured at N+1+RD_LAT, `resp_valid` at N+2+RD_LAT.
- Error: accept at N, `resp_valid` at N+1.
- Throughput is one request per (latency + 1 + response stall) cycles. There is no overlap.
- `resp_ready` held high: RESP lasts exactly one cycle. Held low: stall indefinitely with outputs frozen.
- `rst` asserted in any state clears `mem_we`/`mem_re` immediately. A store interrupted in ISSUE must not produce a clock edge with `mem_we=1`. The pending response is discarded.
- `req_valid` outside IDLE is ignored, and its fields are not sampled.

## Structure

- Package `lsu_pkg` holds:
  - funct3 constants `F3_B/H/W/BU/HU`;
  - FSM state enum `lsu_state_t`;
  - the function `be_of(funct3, addr_lo)`.
- Sub-module `lsu_align` is combinational. It does store lane replication, byte-enable generation and load extraction/extension, so the datapath can be unit-tested separately.
- Top `rv32i_lsu` holds the FSM, request/response registers and the latency counter.

## Test plan

- SB, addr 0x0000_0006, rs2 0xAABBCCDD → `mem_addr=1`, `mem_be=0100`, `mem_wdata=0xDDDDDDDD`, `mem_we` for one cycle; `resp_err=0`.
- With word 1 = 0x80FF7F01: LB addr 0x5 → 0x0000007F; LB addr 0x6 → 0xFFFFFFFF; LBU addr 0x7 → 0x00000080; LH addr 0x6 → 0xFFFF80FF.
- LW addr 0x2 and SH addr 0x3 → `resp_err=1` one cycle after accept, `resp_data=0`, no `mem_we`/`mem_re`. Same for LW at addr 0x0000_4000 with `ADDWIDTH=12` (out of range).
- `RD_LAT=3`, LW addr 0x8 → `resp_valid` exactly 5 cycles after accept. `resp_ready` low for 4 cycles → `resp_data`/`resp_rd` stable throughout, `req_ready=0`.
- `rst` pulsed mid-cycle during ISSUE of SW → `mem_we` drops immediately, memory word unchanged, `resp_valid` never asserted, `req_ready=1` after release.
- Back-to-back SW 0x12345678 to addr 0x10 then LW from addr 0x10 → returns 0x12345678.
